// File: rtl/rst_seq.sv
// Power-on / re-arm reset sequencer: waits out a power-on delay and clock lock,
// then asserts all unmasked channels together and releases them one by one.
module rst_seq #(
    parameter int NUM_CH    = 4,
    parameter int POR_DELAY = 28,
    parameter int PULSE_LEN = 4,
    parameter int STAGGER   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pll_locked,
    input  logic              rst_req,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [NUM_CH-1:0] rst_out,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W    = $clog2(POR_DELAY + PULSE_LEN + (NUM_CH - 1) * STAGGER + 1);
    localparam int LAST_REL = PULSE_LEN + (NUM_CH - 1) * STAGGER - 1;

    typedef enum logic [1:0] {
        S_POR,
        S_WAIT_LOCK,
        S_ASSERT,
        S_DONE
    } state_t;

    // Initialisers match the reset values so the sequence runs straight out of
    // FPGA configuration; state is left as a named signal for checkers to probe.
    state_t            state  = S_POR;
    logic [CNT_W-1:0]  cnt    = '0;
    logic [NUM_CH-1:0] rst_q  = '0;
    logic              busy_q = 1'b1;
    logic              done_q = 1'b0;

    logic [NUM_CH-1:0] rel_hit;

    // rel_hit[i] marks the edge on which channel i drops out of assertion.
    always_comb begin
        rel_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rel_hit[i] = (cnt == CNT_W'(PULSE_LEN + i * STAGGER - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_POR;
            cnt    <= '0;
            rst_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            case (state)
                S_POR: begin
                    rst_q <= rst_q & ~ch_mask;
                    if (cnt == CNT_W'(POR_DELAY - 1)) begin
                        if (pll_locked) begin
                            state  <= S_ASSERT;
                            cnt    <= '0;
                            rst_q  <= ~ch_mask;
                            busy_q <= 1'b1;
                            done_q <= 1'b0;
                        end else begin
                            state <= S_WAIT_LOCK;
                            cnt   <= cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_WAIT_LOCK: begin
                    if (pll_locked) begin
                        state  <= S_ASSERT;
                        cnt    <= '0;
                        rst_q  <= ~ch_mask;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end else begin
                        rst_q <= rst_q & ~ch_mask;
                    end
                end

                S_ASSERT: begin
                    // Lock loss outranks a simultaneous software request.
                    if (!pll_locked) begin
                        state  <= S_WAIT_LOCK;
                        rst_q  <= ~ch_mask;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end else if (rst_req) begin
                        cnt    <= '0;
                        rst_q  <= ~ch_mask;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        rst_q <= rst_q & ~rel_hit & ~ch_mask;
                        if (cnt == CNT_W'(LAST_REL)) begin
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    if (!pll_locked) begin
                        state  <= S_WAIT_LOCK;
                        rst_q  <= ~ch_mask;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end else if (rst_req) begin
                        state  <= S_ASSERT;
                        cnt    <= '0;
                        rst_q  <= ~ch_mask;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end else begin
                        rst_q <= '0;
                    end
                end

                default: begin
                    state  <= S_POR;
                    cnt    <= '0;
                    rst_q  <= '0;
                    busy_q <= 1'b1;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign rst_out = rst_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: directed test-plan scenarios plus randomized lock/request/
// mask/reset traffic, every edge compared against a time-based reference model.
module tb_rst_seq;

    localparam int NUM_CH    = 4;
    localparam int POR_DELAY = 28;
    localparam int PULSE_LEN = 4;
    localparam int STAGGER   = 8;
    localparam int TOTAL     = PULSE_LEN + (NUM_CH - 1) * STAGGER;
    localparam int W         = NUM_CH + 2;

    logic              clk        = 1'b0;
    logic              reset      = 1'b1;
    logic              pll_locked = 1'b1;
    logic              rst_req    = 1'b0;
    logic [NUM_CH-1:0] ch_mask    = '0;
    logic [NUM_CH-1:0] rst_out;
    logic              busy;
    logic              done;

    rst_seq #(
        .NUM_CH    (NUM_CH),
        .POR_DELAY (POR_DELAY),
        .PULSE_LEN (PULSE_LEN),
        .STAGGER   (STAGGER)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_locked (pll_locked),
        .rst_req    (rst_req),
        .ch_mask    (ch_mask),
        .rst_out    (rst_out),
        .busy       (busy),
        .done       (done)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    string phase = "init";

    logic [W-1:0] exp_q[$];

    // Reference model: tracks time since the last assertion start rather than
    // any counter; the expected word is {busy, done, rst_out}.
    bit                m_in_por = 1'b1;
    int                m_por    = 0;
    bit                m_wait   = 1'b0;
    int                m_el     = 0;
    logic [NUM_CH-1:0] m_live   = '0;
    bit                m_busy   = 1'b1;
    bit                m_done   = 1'b0;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
        end
    endtask

    task automatic model_start();
        m_wait = 1'b0;
        m_el   = 0;
        m_live = ~ch_mask;
        m_busy = 1'b1;
        m_done = 1'b0;
    endtask

    task automatic model_edge();
        if (reset) begin
            m_in_por = 1'b1;
            m_por    = 0;
            m_wait   = 1'b0;
            m_el     = 0;
            m_live   = '0;
            m_busy   = 1'b1;
            m_done   = 1'b0;
        end else if (m_in_por) begin
            m_por++;
            m_live &= ~ch_mask;
            if (m_por == POR_DELAY) begin
                m_in_por = 1'b0;
                if (pll_locked) model_start();
                else m_wait = 1'b1;
            end
        end else if (m_wait) begin
            if (pll_locked) model_start();
            else m_live &= ~ch_mask;
        end else if (!pll_locked) begin
            m_wait = 1'b1;
            m_live = ~ch_mask;
            m_busy = 1'b1;
            m_done = 1'b0;
        end else if (rst_req) begin
            model_start();
        end else begin
            m_el++;
            m_live &= ~ch_mask;
            if (m_el >= TOTAL) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    endtask

    function automatic logic [W-1:0] model_out();
        logic [NUM_CH-1:0] o;
        o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_in_por || m_wait) o[i] = m_live[i];
            else o[i] = m_live[i] && (m_el < PULSE_LEN + i * STAGGER);
        end
        return {m_busy, m_done, o};
    endfunction

    // driver: one clock edge, model update, then sample 1ns later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        exp_q.push_back(model_out());
        check_val(phase, {busy, done, rst_out}, exp_q.pop_front());
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) step();
        reset = 1'b0;
    endtask

    int lock_off = 0;

    initial begin
        #1;
        check_val("init_values", {busy, done, rst_out}, {1'b1, 1'b0, 4'b0000});

        // Scenario 1: default power-up with lock present.
        phase = "t1_default";
        pll_locked = 1'b1;
        ch_mask    = '0;
        do_reset(3);
        for (int e = 1; e <= 60; e++) begin
            step();
            case (e)
                27: check_val("t1_e27", {busy, done, rst_out}, {1'b1, 1'b0, 4'b0000});
                28: check_val("t1_e28", {busy, done, rst_out}, {1'b1, 1'b0, 4'b1111});
                32: check_val("t1_e32", {busy, done, rst_out}, {1'b1, 1'b0, 4'b1110});
                40: check_val("t1_e40", {busy, done, rst_out}, {1'b1, 1'b0, 4'b1100});
                48: check_val("t1_e48", {busy, done, rst_out}, {1'b1, 1'b0, 4'b1000});
                55: check_val("t1_e55", {busy, done, rst_out}, {1'b1, 1'b0, 4'b1000});
                56: check_val("t1_e56", {busy, done, rst_out}, {1'b0, 1'b1, 4'b0000});
                default: ;
            endcase
        end

        // Scenario 2: lock arrives late.
        phase = "t2_late_lock";
        pll_locked = 1'b0;
        do_reset(3);
        for (int e = 1; e <= 75; e++) begin
            step();
            if (e == 40) pll_locked = 1'b1;
            case (e)
                40: check_val("t2_e40", {busy, done, rst_out}, {1'b1, 1'b0, 4'b0000});
                41: check_val("t2_e41", {busy, done, rst_out}, {1'b1, 1'b0, 4'b1111});
                45: check_val("t2_e45", {busy, done, rst_out}, {1'b1, 1'b0, 4'b1110});
                53: check_val("t2_e53", {busy, done, rst_out}, {1'b1, 1'b0, 4'b1100});
                61: check_val("t2_e61", {busy, done, rst_out}, {1'b1, 1'b0, 4'b1000});
                69: check_val("t2_e69", {busy, done, rst_out}, {1'b0, 1'b1, 4'b0000});
                default: ;
            endcase
        end

        // Scenario 3: software re-run from DONE.
        phase = "t3_rst_req";
        rst_req = 1'b1;
        step();
        check_val("t3_entry", {busy, done, rst_out}, {1'b1, 1'b0, 4'b1111});
        rst_req = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k == 27) check_val("t3_k27", {busy, done, rst_out}, {1'b1, 1'b0, 4'b1000});
            if (k == 28) check_val("t3_k28", {busy, done, rst_out}, {1'b0, 1'b1, 4'b0000});
        end

        // Scenario 4: lock loss while DONE.
        phase = "t4_lock_loss";
        pll_locked = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check_val("t4_lost", {busy, done, rst_out}, {1'b1, 1'b0, 4'b1111});
        end
        pll_locked = 1'b1;
        step();
        check_val("t4_relock", {busy, done, rst_out}, {1'b1, 1'b0, 4'b1111});
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k == 4)  check_val("t4_k4", {busy, done, rst_out}, {1'b1, 1'b0, 4'b1110});
            if (k == 28) check_val("t4_k28", {busy, done, rst_out}, {1'b0, 1'b1, 4'b0000});
        end

        // Scenario 5: masked channels 0 and 2.
        phase = "t5_mask";
        ch_mask = 4'b0101;
        do_reset(3);
        for (int e = 1; e <= 60; e++) begin
            step();
            case (e)
                28: check_val("t5_e28", {busy, done, rst_out}, {1'b1, 1'b0, 4'b1010});
                39: check_val("t5_e39", {busy, done, rst_out}, {1'b1, 1'b0, 4'b1010});
                40: check_val("t5_e40", {busy, done, rst_out}, {1'b1, 1'b0, 4'b1000});
                56: check_val("t5_e56", {busy, done, rst_out}, {1'b0, 1'b1, 4'b0000});
                default: ;
            endcase
        end
        ch_mask = '0;

        // Scenario 6: reset pulse mid-assertion restarts the power-on delay.
        phase = "t6_mid_reset";
        do_reset(3);
        repeat (35) step();
        reset = 1'b1;
        step();
        check_val("t6_reset", {busy, done, rst_out}, {1'b1, 1'b0, 4'b0000});
        reset = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            step();
            if (e == 27) check_val("t6_e27", {busy, done, rst_out}, {1'b1, 1'b0, 4'b0000});
            if (e == 28) check_val("t6_e28", {busy, done, rst_out}, {1'b1, 1'b0, 4'b1111});
        end

        // Randomized traffic against the model.
        phase = "rand";
        for (int c = 0; c < 4000; c++) begin
            if (lock_off == 0 && $urandom_range(0, 149) == 0) lock_off = $urandom_range(1, 12);
            pll_locked = (lock_off == 0);
            if (lock_off > 0) lock_off--;
            rst_req = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 59) == 0) ch_mask = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
            reset = ($urandom_range(0, 499) == 0);
            step();
        end
        reset   = 1'b0;
        rst_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Parametrised power-on and re-arm reset sequencer. Generates per-channel active-high reset pulses for downstream SDR datapath blocks.
- After a fixed power-on delay, and once the clock source reports lock, all unmasked channels assert together. Channels then release one after another at programmable intervals.
- The sequence re-runs on a software reset request or on loss of lock.
- Register initial values equal their reset values, so the block sequences correctly from FPGA configuration even if the reset input never pulses.

Parameters:
- NUM_CH, 4, number of reset output channels (>=1).
- POR_DELAY, 28, cycles from reset release to the first possible assertion (>=1).
- PULSE_LEN, 4, assertion length of channel 0 in cycles (>=1).
- STAGGER, 8, extra assertion cycles per channel index (>=0).
- CNT_W, $clog2(POR_DELAY+PULSE_LEN+(NUM_CH-1)*STAGGER+1), internal counter width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- reset  in  1  sequencer reset.
- pll_locked  in  1  clock-source lock, synchronous to clk.
- rst_req  in  1  single-cycle request to re-run the pulse sequence.
- ch_mask  in  NUM_CH  1 = channel i never asserts.
- rst_out  out  NUM_CH  per-channel reset outputs, active-high, registered.
- busy  out  1  sequence in progress (POR, WAIT_LOCK, ASSERT).
- done  out  1  all channels released, sequence complete.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: state=POR, counter=0, rst_out=0, busy=1, done=0. These are also the register initial values.
- Edge numbering: edge 1 is the first rising clk edge sampled with reset=0.
- State POR:
  - Counter increments each cycle. rst_out stays 0.
  - At edge POR_DELAY, go to ASSERT if pll_locked=1, else go to WAIT_LOCK.
- State WAIT_LOCK:
  - rst_out holds its value: 0 when entered from POR, unmasked channels high when entered on lock loss.
  - On the first edge sampling pll_locked=1, go to ASSERT.
- Entry to ASSERT:
  - On the same edge: counter cleared to 0, rst_out[i] set to ~ch_mask[i], done=0, busy=1.
- State ASSERT:
  - Counter increments each cycle.
  - Channel i releases (rst_out[i]<=0) on the edge where counter reaches PULSE_LEN+i*STAGGER-1. Total high time is therefore PULSE_LEN+i*STAGGER cycles.
  - With STAGGER=0, all channels release on the same edge.
  - On the release edge of channel NUM_CH-1: go to DONE, done<=1, busy<=0.
- State DONE:
  - rst_out=0, counter frozen. Stays here until an event.
- rst_req=1 in ASSERT or DONE:
  - Restart ASSERT: counter cleared, all unmasked channels re-asserted, done<=0.
  - Full PULSE_LEN+i*STAGGER applies from that edge.
- rst_req=1 in POR or WAIT_LOCK: ignored; the pending sequence will run anyway.
- pll_locked=0 sampled in ASSERT or DONE:
  - Go to WAIT_LOCK. All unmasked channels driven high. done<=0, busy<=1.
  - Lock loss has priority over rst_req on the same edge.
- ch_mask:
  - Sampled every edge. rst_out[i] is forced to 0 on the next edge whenever ch_mask[i]=1.
  - Clearing a mask bit mid-sequence does not re-assert that channel until the next ASSERT entry.
  - ch_mask all ones: sequence timing, busy and done behave as normal; rst_out stays 0.
- reset=1 at any time: all registers return to reset values on that edge, regardless of state. The power-on delay is re-run in full.
- Counter never wraps: its maximum reachable value is below 2^CNT_W.

Test Plan:
- Defaults, pll_locked=1, ch_mask=0, reset high 3 cycles then low → rst_out=0 through edge 27; rst_out=4'b1111 at edge 28. Bits release at edges 32, 40, 48, 56. busy falls and done rises at edge 56.
- pll_locked held 0 until edge 40, then 1 → rst_out=0 through edge 40; all high from the first edge sampling lock=1. Release offsets +4/+12/+20/+28 from that edge.
- In DONE, pulse rst_req one cycle → rst_out=4'b1111 next edge, done=0. Channel 3 releases 28 cycles later and done returns to 1.
- In DONE, drop pll_locked for 10 cycles → rst_out=4'b1111 and busy=1 throughout. Full stagger sequence runs after relock.
- ch_mask=4'b0101, full sequence → rst_out[0] and rst_out[2] never go high. Bits 1 and 3 follow the default timing. done rises at edge 56.
- Assert reset for 1 cycle at edge 35 (mid-ASSERT) → rst_out=0, busy=1, done=0 next edge. The full 28-cycle POR delay restarts.
